// File: rtl/interp_pkg.sv
// Shared widths and the packed MCM product-bus type for the 8-tap interpolation sum.
package interp_pkg;

  localparam int unsigned NTAPS    = 8;
  localparam int unsigned NFRAC    = 15;
  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned ACC_W    = 35;
  localparam int unsigned FRAC_W   = 4;

  // Element [k] carries Y(k+1); Y1 sits in bits [31:0].
  typedef logic [NFRAC-1:0][SAMPLE_W-1:0] prod_bus_t;

endpackage

// File: rtl/interp_frac_mux.sv
// 15:1 selector returning Y[frac] from one tap's packed product bus; zero when frac=0.
module interp_frac_mux
  import interp_pkg::*;
(
  input  prod_bus_t                  prod,
  input  logic [FRAC_W-1:0]          frac,
  output logic signed [SAMPLE_W-1:0] sel_c
);

  always_comb begin
    sel_c = '0;
    for (int j = 0; j < NFRAC; j++) begin
      if (frac == FRAC_W'(j + 1)) sel_c = prod[j];
    end
  end

endmodule

// File: rtl/interp_tap_sum.sv
// 3-stage 8-tap interpolation sum with round/shift and integer bypass.
// Define INTERP_TAP_SUM_CLIP_EN to clip fractional results to [0, 2^BITDEPTH-1].
module interp_tap_sum
  import interp_pkg::*;
#(
  parameter int unsigned SHIFT    = 6,
  parameter int unsigned BITDEPTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FRAC_W-1:0]          frac,
  input  logic signed [SAMPLE_W-1:0] center_x,
  input  prod_bus_t                  prod_t0,
  input  prod_bus_t                  prod_t1,
  input  prod_bus_t                  prod_t2,
  input  prod_bus_t                  prod_t3,
  input  prod_bus_t                  prod_t4,
  input  prod_bus_t                  prod_t5,
  input  prod_bus_t                  prod_t6,
  input  prod_bus_t                  prod_t7,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_sample
);

  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);
`ifdef INTERP_TAP_SUM_CLIP_EN
  localparam logic signed [ACC_W-1:0] CLIP_MAX = ACC_W'((64'd1 << BITDEPTH) - 64'd1);
`endif

  if (SHIFT == 0 || SHIFT >= ACC_W) begin : g_bad_shift
    $error("interp_tap_sum: SHIFT must be in 1..34");
  end
  if (BITDEPTH == 0 || BITDEPTH >= SAMPLE_W) begin : g_bad_bitdepth
    $error("interp_tap_sum: BITDEPTH must be in 1..31");
  end

  prod_bus_t                  taps  [NTAPS];
  logic signed [SAMPLE_W-1:0] sel_c [NTAPS];

  assign taps[0] = prod_t0;
  assign taps[1] = prod_t1;
  assign taps[2] = prod_t2;
  assign taps[3] = prod_t3;
  assign taps[4] = prod_t4;
  assign taps[5] = prod_t5;
  assign taps[6] = prod_t6;
  assign taps[7] = prod_t7;

  for (genvar t = 0; t < NTAPS; t++) begin : g_tap
    interp_frac_mux u_mux (
      .prod  (taps[t]),
      .frac  (frac),
      .sel_c (sel_c[t])
    );
  end

  // Whole pipeline advances together; only a held output stalls it.
  logic adv_c;
  assign adv_c    = ~(out_valid & ~out_ready);
  assign in_ready = rst | adv_c;

  logic                       s1_valid;
  logic                       s1_bypass;
  logic signed [SAMPLE_W-1:0] s1_center;
  logic signed [SAMPLE_W-1:0] s1_sel [NTAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_bypass <= 1'b0;
      s1_center <= '0;
      for (int t = 0; t < NTAPS; t++) s1_sel[t] <= '0;
    end else if (adv_c) begin
      s1_valid  <= in_valid;
      s1_bypass <= (frac == '0);
      s1_center <= center_x;
      for (int t = 0; t < NTAPS; t++) s1_sel[t] <= sel_c[t];
    end
  end

  logic signed [ACC_W-1:0] p0_c;
  logic signed [ACC_W-1:0] p1_c;

  always_comb begin
    p0_c = '0;
    p1_c = '0;
    for (int t = 0; t < NTAPS / 2; t++) begin
      p0_c = p0_c + ACC_W'(s1_sel[t]);
      p1_c = p1_c + ACC_W'(s1_sel[t + NTAPS / 2]);
    end
  end

  logic                       s2_valid;
  logic                       s2_bypass;
  logic signed [SAMPLE_W-1:0] s2_center;
  logic signed [ACC_W-1:0]    s2_p0;
  logic signed [ACC_W-1:0]    s2_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_bypass <= 1'b0;
      s2_center <= '0;
      s2_p0     <= '0;
      s2_p1     <= '0;
    end else if (adv_c) begin
      s2_valid  <= s1_valid;
      s2_bypass <= s1_bypass;
      s2_center <= s1_center;
      s2_p0     <= p0_c;
      s2_p1     <= p1_c;
    end
  end

  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W-1:0] shr_c;
  logic signed [ACC_W-1:0] res_c;

  always_comb begin
    sum_c = s2_p0 + s2_p1;
    shr_c = (sum_c + RND) >>> SHIFT;
    res_c = shr_c;
`ifdef INTERP_TAP_SUM_CLIP_EN
    if (shr_c[ACC_W-1]) begin
      res_c = '0;
    end else if (shr_c > CLIP_MAX) begin
      res_c = CLIP_MAX;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else if (adv_c) begin
      out_valid  <= s2_valid;
      out_sample <= s2_bypass ? s2_center : SAMPLE_W'(res_c);
    end
  end

endmodule

// File: tb/tb_interp_tap_sum.sv
// Directed bench for interp_tap_sum: reference model feeds a scoreboard queue, negedge monitor pops.
module tb_interp_tap_sum;
  import interp_pkg::*;

  logic                       clk;
  logic                       rst;
  logic                       in_valid;
  logic                       in_ready;
  logic [3:0]                 frac;
  logic signed [31:0]         center_x;
  prod_bus_t                  prod [8];
  logic                       out_valid;
  logic                       out_ready;
  logic signed [31:0]         out_sample;

  int checks = 0;
  int errors = 0;
  int nout = 0;
  int last_waits = 0;
  int nbase;
  logic signed [31:0] sb [$];

  interp_tap_sum dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .frac       (frac),
    .center_x   (center_x),
    .prod_t0    (prod[0]),
    .prod_t1    (prod[1]),
    .prod_t2    (prod[2]),
    .prod_t3    (prod[3]),
    .prod_t4    (prod[4]),
    .prod_t5    (prod[5]),
    .prod_t6    (prod[6]),
    .prod_t7    (prod[7]),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: floor((sum + 32) / 64), optional clip to 10-bit range.
  function automatic logic signed [31:0] model(input int f, input int c, input longint s);
    longint r;
    if (f == 0) return 32'(c);
    r = s + 64'sd32;
    r = (r - (((r % 64) + 64) % 64)) / 64;
`ifdef INTERP_TAP_SUM_CLIP_EN
    if (r < 0) r = 0;
    if (r > 1023) r = 1023;
`endif
    return 32'(r);
  endfunction

  // Tap k gets Y[f] = base + k*step; every other Y position is random junk.
  task automatic send(input int f, input int c, input int base, input int step);
    logic acc;
    longint s;
    s = 8 * longint'(base) + 28 * longint'(step);
    frac     = 4'(f);
    center_x = 32'(c);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 15; j++)
        prod[k][j] = (j == f - 1) ? 32'(base + k * step) : $urandom;
    in_valid   = 1'b1;
    last_waits = 0;
    acc        = 1'b0;
    while (!acc && last_waits <= 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) last_waits++;
    end
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout observed=%0d expected=1", acc);
    end
    if (acc) sb.push_back(model(f, c, s));
    in_valid = 1'b0;
  endtask

  // Called right after send returns (cycle t+1): valid must rise in cycle t+3.
  task automatic check_latency(input string tag);
    chk({tag, "_lat1"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    chk({tag, "_lat3"}, 32'(out_valid), 1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output observed=%0d expected=none", out_sample);
      end
      if (sb.size() != 0) begin
        chk("sample", out_sample, sb.pop_front());
        nout++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    frac      = '0;
    center_x  = '0;
    for (int k = 0; k < 8; k++) prod[k] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // First edge after reset accepts; basic sum 8*16=128 -> 2.
    rst = 1'b0;
    send(4, 0, 16, 0);
    chk("first_accept_waits", last_waits, 0);
    check_latency("basic");
    drain("basic");

    // Back-to-back stream: bypass, negative, overflow, distinct taps, rounding edges.
    send(0, -123, 999, 7);
    send(8, 0, -80, 0);
    send(8, 0, 8750, 0);
    send(15, 0, 100, 100);
    send(1, 0, -1000, 37);
    chk("stream_waits", last_waits, 0);
    send(2, 0, 4, 0);
    send(3, 0, -4, 0);
    send(7, 0, -5, 1);
    drain("stream");

    // Backpressure: 6 bypass samples, out_ready low in cycles 4-7.
    nbase = nout;
    fork
      begin
        for (int v = 1; v <= 6; v++) send(0, v, 0, 0);
      end
      begin
        repeat (4) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_hold", out_sample, 2);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp");
    chk("bp_count", nout - nbase, 6);

    // Reset with three samples in flight (output held so none escape).
    out_ready = 1'b0;
    send(0, 11, 0, 0);
    send(0, 12, 0, 0);
    send(0, 13, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_sample", out_sample, 0);
    sb.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    nbase     = nout;
    send(0, 77, 0, 0);
    chk("post_rst_waits", last_waits, 0);
    check_latency("post_rst");
    drain("post_rst");
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_count", nout - nbase, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
